ring_stop: RTL



---
 rtl/ring_stop.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ring_stop.sv
// Ring stop: classifies upstream packets (sink / broadcast / retire / orphan /
// forward), drives the downstream output register, and injects packets from
// the node's outbound FIFO with bounded-starvation arbitration.

package ring_stop_pkg;
  typedef struct packed {
    logic        valid;
    logic        broadcast;
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [15:0] payload;
  } ring_packet_t;
endpackage

module ring_stop
  import ring_stop_pkg::*;
#(
  parameter logic [3:0]  NODE_ID      = 4'd0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  ring_packet_t ring_in,
  output logic         ring_in_ready,
  output ring_packet_t ring_out,
  input  logic         ring_out_ready,
  output ring_packet_t inbound_fifo_data,
  output logic         inbound_fifo_wrreq,
  input  logic         inbound_fifo_full,
  input  ring_packet_t outbound_fifo_q,
  output logic         outbound_fifo_rdreq,
  input  logic         outbound_fifo_empty,
  output logic         orphan_drop
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {INJ_IDLE, INJ_READ, INJ_PEND} inj_state_t;

  inj_state_t   inj_state;
  ring_packet_t inj_reg;
  ring_packet_t inj_pkt;
  logic [CW-1:0] starve_cnt;

  logic is_sink, is_bcast, is_orphan, is_fwd;
  logic slot_free, hold, inj_prio, inj_ready;
  logic sink_ok, fwd_ok, accept, transit, inj_load;

  // Packet classification and ring_in handshake
  always_comb begin
    is_sink   = !ring_in.broadcast && (ring_in.dest == NODE_ID);
    is_bcast  = ring_in.broadcast && (ring_in.src != NODE_ID);
    is_orphan = !ring_in.broadcast && (ring_in.src == NODE_ID) && (ring_in.dest != NODE_ID);
    // Retire (broadcast from this node) is the remaining broadcast case.
    is_fwd    = !ring_in.broadcast && !is_sink && !is_orphan;

    slot_free = !ring_out.valid || ring_out_ready;
    hold      = ring_out.valid && !ring_out_ready;
    inj_prio  = (starve_cnt == LIMIT);
    sink_ok   = !inbound_fifo_full;
    fwd_ok    = slot_free && !inj_prio;

    if (is_sink)       ring_in_ready = sink_ok;
    else if (is_bcast) ring_in_ready = sink_ok && fwd_ok;
    else if (is_fwd)   ring_in_ready = fwd_ok;
    else               ring_in_ready = 1'b1;

    accept  = ring_in.valid && ring_in_ready;
    transit = accept && (is_fwd || is_bcast);

    inbound_fifo_data  = ring_in;
    inbound_fifo_wrreq = accept && (is_sink || is_bcast);
    orphan_drop        = accept && is_orphan;
  end

  // Injection source select and output-slot arbitration
  always_comb begin
    inj_ready = (inj_state == INJ_READ) || (inj_state == INJ_PEND);
    inj_pkt   = (inj_state == INJ_READ) ? outbound_fifo_q : inj_reg;
    // Anything drained from the outbound FIFO is a real packet on the ring.
    inj_pkt.valid = 1'b1;
    inj_load  = !hold && inj_ready && (inj_prio || !transit);
    outbound_fifo_rdreq = (inj_state == INJ_IDLE) && !outbound_fifo_empty;
  end

  // Downstream output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      ring_out <= '0;
    else if (hold)     ring_out <= ring_out;
    else if (inj_load) ring_out <= inj_pkt;
    else if (transit)  ring_out <= ring_in;
    else               ring_out <= '0;
  end

  // Injection FSM: one outstanding read, parks data in inj_reg if it cannot load
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inj_state <= INJ_IDLE;
      inj_reg   <= '0;
    end else begin
      unique case (inj_state)
        INJ_IDLE: if (outbound_fifo_rdreq) inj_state <= INJ_READ;
        INJ_READ: begin
          if (inj_load) begin
            inj_state <= INJ_IDLE;
          end else begin
            inj_reg   <= outbound_fifo_q;
            inj_state <= INJ_PEND;
          end
        end
        INJ_PEND: if (inj_load) inj_state <= INJ_IDLE;
        default:  inj_state <= INJ_IDLE;
      endcase
    end
  end

  // Starvation counter: counts cycles where a free slot went to transit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                    starve_cnt <= '0;
    else if (inj_load)                               starve_cnt <= '0;
    else if (inj_ready && slot_free && transit && starve_cnt != LIMIT)
                                                     starve_cnt <= starve_cnt + 1'b1;
  end

endmodule
